// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: shared state type, CRC constants and header offsets for the RMII receiver
package eth_rx_pkg;
    typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, END, DROP} rx_state_t;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam int OFF_DST = 0;
    localparam int OFF_SRC = 6;
    localparam int OFF_TYPE = 12;
    localparam int OFF_PROTO = 23;
    localparam int OFF_IP_SRC = 26;
    localparam int OFF_IP_DST = 30;
    localparam int OFF_PORTS = 34;
    localparam int OFF_SEQ = 38;
    localparam int OFF_ACK = 42;
    function automatic logic in_field(input logic [10:0] idx, input int off, input int len);
        return int'(idx) >= off && int'(idx) < off + len;
    endfunction
endpackage

// File: rtl/crc32_byte_rx.sv
// crc32_byte_rx: byte-serial reflected CRC-32 accumulator
module crc32_byte_rx
    import eth_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  data,
    output logic [31:0] crc
);
    logic [31:0] nxt;
    // fold one byte into the running remainder, LSB first
    always_comb begin
        nxt = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) nxt = nxt[0] ? (nxt >> 1) ^ CRC32_POLY_REFL : nxt >> 1;
    end
    // remainder register, reseeded between frames
    always_ff @(posedge clk) crc <= (rst || clear) ? 32'hFFFF_FFFF : byte_valid ? nxt : crc;
endmodule

// File: rtl/rmii_frame_receiver.sv
// rmii_frame_receiver: RMII dibit receiver with CRC/length checks, header capture and FCS-stripped payload
module rmii_frame_receiver
    import eth_rx_pkg::*;
#(
    parameter int MIN_FRAME_BYTES = 64,
    parameter int MAX_FRAME_BYTES = 1518,
    parameter int HDR_BYTES = 54,
    parameter logic FILTER_EN = 1'b0,
    parameter logic [47:0] LOCAL_MAC = 48'h0
) (
    input  logic        clk_50_mhz,
    input  logic        rst,
    input  logic [1:0]  rx_d,
    input  logic        crs_dv,
    output logic [47:0] eth_dst,
    output logic [47:0] eth_src,
    output logic [15:0] eth_type,
    output logic [7:0]  ip_proto,
    output logic [31:0] ip_src,
    output logic [31:0] ip_dst,
    output logic [31:0] tcp_ports,
    output logic [31:0] tcp_seq,
    output logic [31:0] tcp_ack,
    output logic [7:0]  pl_data,
    output logic        pl_valid,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        crc_err,
    output logic        len_err,
    output logic        align_err,
    output logic [10:0] frame_len,
    output logic        busy
);
    rx_state_t state, state_n;
    logic [1:0] dib_cnt;
    logic [5:0] sh;
    logic [10:0] byte_cnt;
    logic len_drop;
    logic [31:0] crc;
    logic [47:0] s_dst, s_src;
    logic [15:0] s_type;
    logic [7:0] s_proto;
    logic [31:0] s_ip_src, s_ip_dst, s_ports, s_seq, s_ack;
    logic [7:0] fifo [4];
    logic [2:0] fcnt;
    logic [7:0] nbyte;
    logic at_max, dv, bstb, c_crc, c_len, c_align, c_ok;
    assign nbyte = {rx_d, sh};
    assign at_max = byte_cnt == 11'(MAX_FRAME_BYTES);
    assign dv = state == DATA && crs_dv && !at_max;
    assign bstb = dv && dib_cnt == 2'd3;
    assign c_crc = crc != CRC32_RESIDUE;
    assign c_len = byte_cnt < 11'(MIN_FRAME_BYTES) || byte_cnt > 11'(MAX_FRAME_BYTES);
    assign c_align = dib_cnt != 2'd0;
    assign c_ok = !c_crc && !c_len && !c_align && (!FILTER_EN || s_dst == LOCAL_MAC || s_dst == BCAST_MAC);
    assign busy = state != IDLE;
    crc32_byte_rx u_crc (
        .clk(clk_50_mhz),
        .rst(rst),
        .clear(state == PREAMBLE),
        .byte_valid(bstb),
        .data(nbyte),
        .crc(crc)
    );
    // frame sequencing: preamble hunt, data capture, one-cycle evaluation, oversize drop
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = (crs_dv && rx_d == 2'b01) ? PREAMBLE : IDLE;
            PREAMBLE: state_n = !crs_dv ? IDLE : rx_d == 2'b01 ? PREAMBLE : rx_d == 2'b11 ? DATA : DROP;
            DATA:     state_n = !crs_dv ? END : at_max ? DROP : DATA;
            END:      state_n = IDLE;
            DROP:     state_n = crs_dv ? DROP : IDLE;
            default:  state_n = IDLE;
        endcase
    end
    // byte assembly, header shadowing, payload delay line and end-of-frame reporting
    always_ff @(posedge clk_50_mhz) begin
        if (rst) begin
            state <= IDLE;
            dib_cnt <= '0;
            sh <= '0;
            byte_cnt <= '0;
            len_drop <= 1'b0;
            fcnt <= '0;
            {s_dst, s_src, s_type, s_proto, s_ip_src, s_ip_dst, s_ports, s_seq, s_ack} <= '0;
            {eth_dst, eth_src, eth_type, ip_proto, ip_src, ip_dst, tcp_ports, tcp_seq, tcp_ack} <= '0;
            {pl_data, pl_valid, frame_done, frame_ok, crc_err, len_err, align_err, frame_len} <= '0;
        end else begin
            state <= state_n;
            pl_valid <= 1'b0;
            frame_done <= 1'b0;
            if (state == PREAMBLE) begin
                dib_cnt <= '0;
                byte_cnt <= '0;
                len_drop <= 1'b0;
                fcnt <= '0;
            end
            if (dv) begin
                sh <= nbyte[7:2];
                dib_cnt <= dib_cnt + 2'd1;
            end
            if (bstb) begin
                byte_cnt <= byte_cnt + 11'd1;
                if (in_field(byte_cnt, OFF_DST, 6)) s_dst <= {s_dst[39:0], nbyte};
                if (in_field(byte_cnt, OFF_SRC, 6)) s_src <= {s_src[39:0], nbyte};
                if (in_field(byte_cnt, OFF_TYPE, 2)) s_type <= {s_type[7:0], nbyte};
                if (in_field(byte_cnt, OFF_PROTO, 1)) s_proto <= nbyte;
                if (in_field(byte_cnt, OFF_IP_SRC, 4)) s_ip_src <= {s_ip_src[23:0], nbyte};
                if (in_field(byte_cnt, OFF_IP_DST, 4)) s_ip_dst <= {s_ip_dst[23:0], nbyte};
                if (in_field(byte_cnt, OFF_PORTS, 4)) s_ports <= {s_ports[23:0], nbyte};
                if (in_field(byte_cnt, OFF_SEQ, 4)) s_seq <= {s_seq[23:0], nbyte};
                if (in_field(byte_cnt, OFF_ACK, 4)) s_ack <= {s_ack[23:0], nbyte};
                if (byte_cnt >= 11'(HDR_BYTES)) begin
                    fifo[0] <= fifo[1];
                    fifo[1] <= fifo[2];
                    fifo[2] <= fifo[3];
                    fifo[3] <= nbyte;
                    fcnt <= fcnt + {2'b0, fcnt != 3'd4};
                    if (fcnt == 3'd4) begin
                        pl_data <= fifo[0];
                        pl_valid <= 1'b1;
                    end
                end
            end
            if (state == DATA && crs_dv && at_max) len_drop <= 1'b1;
            if (state == END) begin
                frame_done <= 1'b1;
                frame_ok <= c_ok;
                crc_err <= c_crc;
                len_err <= c_len;
                align_err <= c_align;
                frame_len <= byte_cnt;
                if (c_ok) {eth_dst, eth_src, eth_type, ip_proto, ip_src, ip_dst, tcp_ports, tcp_seq, tcp_ack} <=
                    {s_dst, s_src, s_type, s_proto, s_ip_src, s_ip_dst, s_ports, s_seq, s_ack};
            end
            if (state == DROP && !crs_dv && len_drop) begin
                frame_done <= 1'b1;
                frame_ok <= 1'b0;
                crc_err <= 1'b0;
                len_err <= 1'b1;
                align_err <= 1'b0;
                frame_len <= byte_cnt;
            end
            if (state == END || state == DROP) fcnt <= '0;
        end
    end
endmodule

// File: tb/tb_rmii_frame_receiver.sv
// tb_rmii_frame_receiver: directed self-checking bench for the RMII frame receiver
module tb_rmii_frame_receiver;
  localparam logic [47:0] LOCAL = 48'h0203_0405_0607;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] OTHER = 48'h0203_0405_0608;
  localparam logic [47:0] SRC = 48'h0A0B_0C0D_0E0F;
  localparam logic [47:0] SRC2 = 48'h1111_2222_3333;
  localparam logic [31:0] IPS = 32'hC0A8_0001;
  localparam logic [31:0] IPD = 32'hC0A8_0002;
  localparam logic [31:0] PRT = 32'h1234_0050;
  localparam logic [31:0] SEQ = 32'h0102_0304;
  localparam logic [31:0] ACK = 32'hA1B2_C3D4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] rx_d = 2'b00;
  logic crs_dv = 1'b0;
  logic [47:0] eth_dst, eth_src;
  logic [15:0] eth_type;
  logic [7:0] ip_proto, pl_data;
  logic [31:0] ip_src, ip_dst, tcp_ports, tcp_seq, tcp_ack;
  logic pl_valid, frame_done, frame_ok, crc_err, len_err, align_err, busy;
  logic [10:0] frame_len;
  logic [7:0] fr [1600];
  logic [7:0] pl_buf [2048];
  int pl_n = 0, done_n = 0, ok_n = 0, vecs = 0, errs = 0, pb, db, ob;
  always #10 clk = ~clk;
  rmii_frame_receiver #(.FILTER_EN(1'b1), .LOCAL_MAC(LOCAL)) dut (
    .clk_50_mhz(clk), .rst(rst), .rx_d(rx_d), .crs_dv(crs_dv),
    .eth_dst(eth_dst), .eth_src(eth_src), .eth_type(eth_type), .ip_proto(ip_proto),
    .ip_src(ip_src), .ip_dst(ip_dst), .tcp_ports(tcp_ports), .tcp_seq(tcp_seq), .tcp_ack(tcp_ack),
    .pl_data(pl_data), .pl_valid(pl_valid), .frame_done(frame_done), .frame_ok(frame_ok),
    .crc_err(crc_err), .len_err(len_err), .align_err(align_err), .frame_len(frame_len), .busy(busy)
  );
  always @(negedge clk) begin
    if (!rst && pl_valid) begin
      pl_buf[pl_n % 2048] = pl_data;
      pl_n++;
    end
    if (!rst && frame_done) begin
      done_n++;
      if (frame_ok) ok_n++;
    end
  end
  task automatic chk(input string tag, input logic ok);
    vecs++;
    if (ok !== 1'b1) begin
      errs++;
      $error("FAIL %s", tag);
    end
  endtask
  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {24'h0, fr[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 32'hEDB8_8320 : c >> 1;
    end
    return ~c;
  endfunction
  task automatic build(input logic [47:0] dst, input logic [47:0] src, input int n);
    logic [31:0] f;
    for (int i = 0; i < n; i++) fr[i] = i[7:0];
    for (int i = 0; i < 6; i++) begin
      fr[i] = dst[47-8*i -: 8];
      fr[6+i] = src[47-8*i -: 8];
    end
    fr[12] = 8'h08;
    fr[13] = 8'h00;
    fr[23] = 8'h06;
    for (int i = 0; i < 4; i++) begin
      fr[26+i] = IPS[31-8*i -: 8];
      fr[30+i] = IPD[31-8*i -: 8];
      fr[34+i] = PRT[31-8*i -: 8];
      fr[38+i] = SEQ[31-8*i -: 8];
      fr[42+i] = ACK[31-8*i -: 8];
    end
    f = fcs_of(n - 4);
    for (int i = 0; i < 4; i++) fr[n-4+i] = f[8*i +: 8];
  endtask
  task automatic drive(input logic [1:0] d);
    @(negedge clk);
    crs_dv = 1'b1;
    rx_d = d;
  endtask
  task automatic pre();
    for (int i = 0; i < 32; i++) drive(i == 31 ? 2'b11 : 2'b01);
  endtask
  task automatic dibs(input int n);
    for (int i = 0; i < n; i++) drive(fr[i/4][2*(i%4) +: 2]);
  endtask
  task automatic stop();
    @(negedge clk);
    crs_dv = 1'b0;
    rx_d = 2'b00;
  endtask
  task automatic send(input int ndib);
    pre();
    dibs(ndib);
    stop();
  endtask
  task automatic wait_done(input int target);
    for (int i = 0; i < 40 && done_n < target; i++) @(negedge clk);
    #1;
  endtask
  initial begin
    #200000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("reset busy", busy === 1'b0);
    chk("reset frame_done", frame_done === 1'b0);
    chk("reset frame_ok", frame_ok === 1'b0);
    chk("reset eth_dst", eth_dst === 48'h0);
    chk("reset frame_len", frame_len === 11'd0);
    build(LOCAL, SRC, 64);
    pb = pl_n; db = done_n;
    send(64 * 4);
    wait_done(db + 1);
    chk("c1 done", done_n === db + 1);
    chk("c1 ok", frame_ok === 1'b1);
    chk("c1 crc_err", crc_err === 1'b0);
    chk("c1 len", frame_len === 11'd64);
    chk("c1 pl count", pl_n - pb === 6);
    for (int k = 0; k < 6; k++) chk("c1 pl byte", pl_buf[(pb + k) % 2048] === 8'(54 + k));
    chk("c1 eth_dst", eth_dst === LOCAL);
    chk("c1 eth_src", eth_src === SRC);
    chk("c1 eth_type", eth_type === 16'h0800);
    chk("c1 ip_proto", ip_proto === 8'h06);
    chk("c1 ip_src", ip_src === IPS);
    chk("c1 ip_dst", ip_dst === IPD);
    chk("c1 tcp_ports", tcp_ports === PRT);
    chk("c1 tcp_seq", tcp_seq === SEQ);
    chk("c1 tcp_ack", tcp_ack === ACK);
    fr[20] = fr[20] ^ 8'h08;
    pb = pl_n; db = done_n;
    send(64 * 4);
    wait_done(db + 1);
    chk("c2 done", done_n === db + 1);
    chk("c2 crc_err", crc_err === 1'b1);
    chk("c2 ok", frame_ok === 1'b0);
    chk("c2 pl count", pl_n - pb === 6);
    chk("c2 eth_src held", eth_src === SRC);
    build(LOCAL, SRC2, 64);
    db = done_n;
    send(10);
    wait_done(db + 1);
    chk("c3 done", done_n === db + 1);
    chk("c3 align_err", align_err === 1'b1);
    chk("c3 ok", frame_ok === 1'b0);
    chk("c3 len", frame_len === 11'd2);
    build(LOCAL, SRC2, 60);
    pb = pl_n; db = done_n;
    send(60 * 4);
    wait_done(db + 1);
    chk("c3b done", done_n === db + 1);
    chk("c3b len_err", len_err === 1'b1);
    chk("c3b crc_err", crc_err === 1'b0);
    chk("c3b align_err", align_err === 1'b0);
    chk("c3b ok", frame_ok === 1'b0);
    chk("c3b len", frame_len === 11'd60);
    chk("c3b pl count", pl_n - pb === 2);
    chk("c3b eth_src held", eth_src === SRC);
    build(LOCAL, SRC2, 1600);
    pb = pl_n; db = done_n;
    send(1600 * 4);
    wait_done(db + 1);
    chk("c4 done", done_n === db + 1);
    chk("c4 len_err", len_err === 1'b1);
    chk("c4 ok", frame_ok === 1'b0);
    chk("c4 len", frame_len === 11'd1518);
    chk("c4 pl count", pl_n - pb === 1460);
    chk("c4 eth_src held", eth_src === SRC);
    build(BCAST, SRC2, 64);
    db = done_n;
    send(64 * 4);
    wait_done(db + 1);
    chk("c5 bcast ok", frame_ok === 1'b1);
    chk("c5 bcast eth_dst", eth_dst === BCAST);
    chk("c5 bcast eth_src", eth_src === SRC2);
    build(OTHER, SRC, 64);
    db = done_n;
    send(64 * 4);
    wait_done(db + 1);
    chk("c5 other done", done_n === db + 1);
    chk("c5 other ok", frame_ok === 1'b0);
    chk("c5 other flags", {crc_err, len_err, align_err} === 3'b000);
    chk("c5 other eth_dst held", eth_dst === BCAST);
    build(LOCAL, SRC, 64);
    db = done_n;
    pre();
    dibs(30 * 4);
    @(negedge clk);
    rst = 1'b1;
    crs_dv = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("c6 no done on abort", done_n === db);
    chk("c6 busy after rst", busy === 1'b0);
    chk("c6 eth_dst cleared", eth_dst === 48'h0);
    db = done_n; ob = ok_n;
    send(64 * 4);
    repeat (11) @(negedge clk);
    send(64 * 4);
    wait_done(db + 2);
    chk("c6 b2b done", done_n === db + 2);
    chk("c6 b2b ok", ok_n === ob + 2);
    chk("c6 eth_dst", eth_dst === LOCAL);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
